// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory fetcher feeding a
// DEPTH-entry {pc, inst} buffer, with redirect flush and stale-response drop.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; waits for buffer space and no redirect
// WAIT  | request at fetch_pc outstanding; response is pushed on ack
// DROP  | request at a stale address outstanding; response discarded
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      buf_pc_q   [DEPTH];
    logic [31:0]      buf_pc_d   [DEPTH];
    logic [31:0]      buf_inst_q [DEPTH];
    logic [31:0]      buf_inst_d [DEPTH];

    logic             push;
    logic             pop;
    logic [31:0]      redirect_base;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        redirect_base = {redirect_pc[31:2], 2'b00};
        push = (state_q == S_WAIT) && mem_ack && !redirect_valid && (count_q != FULL_CNT);
        pop  = (count_q != '0) && inst_ready && !redirect_valid;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        if (push) begin
            buf_pc_d[wr_ptr_q]   = fetch_pc_q;
            buf_inst_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            fetch_pc_d           = fetch_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // A redirect wins over everything: flush, retarget, never push or pop.
        if (redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_base;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && (count_q < FULL_CNT)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = mem_ack ? S_IDLE : S_DROP;
                end else if (mem_ack) begin
                    state_d = (push && (count_d < FULL_CNT)) ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d = (state_d != S_IDLE);
        // The request address only moves when a fresh request is issued;
        // in DROP it keeps pointing at the abandoned address.
        req_addr_d = (state_d == S_WAIT) ? fetch_pc_d : req_addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_inst_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = buf_inst_q[rd_ptr_q];
    assign inst_pc    = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder with programmable
// wait states, expected-pc scoreboard, table of redirect cases, hand sequences.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          mem_delay = 0;
    int          mem_cnt   = 0;
    int          ack_cnt   = 0;
    int          pop_cnt   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    typedef struct {
        logic [31:0] rd_pc;
        int          delay;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs[5];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_seq(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_pops(input int n, input int lim, input string name);
        int target;
        int k;
        target = pop_cnt + n;
        k = 0;
        while (pop_cnt < target && k < lim) begin
            tick();
            k++;
        end
        check1(name, pop_cnt >= target, 1'b1);
    endtask

    task automatic wait_req_rise(input int lim, output logic rose);
        logic prev;
        int   k;
        prev = mem_req;
        rose = 1'b0;
        k = 0;
        while (!rose && k < lim) begin
            tick();
            k++;
            rose = !prev && mem_req;
            prev = mem_req;
        end
    endtask

    // Memory responder: mem_delay wait cycles before each ack.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (mem_cnt >= mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = inst_of(mem_addr);
                mem_cnt   = 0;
                ack_cnt++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                mem_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    // Every consumed instruction must match the head of the expected-pc queue.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, want no instruction", inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_pc", inst_pc, mon_e);
                check("pop_inst", inst, inst_of(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] old;
        logic        rose;
        int          p0;
        int          k;

        vecs[0] = '{32'h0000_0100, 3, 32'h0000_0100};
        vecs[1] = '{32'h0000_0203, 0, 32'h0000_0200};
        vecs[2] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8};
        vecs[3] = '{32'h0000_1001, 2, 32'h0000_1000};
        vecs[4] = '{32'h0000_0FFF, 0, 32'h0000_0FFC};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = 32'h0;

        #3;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        repeat (3) tick();

        // Zero-wait streaming from reset.
        inst_ready = 1'b1;
        mem_delay  = 0;
        load_seq(RESET_PC);
        reset = 1'b0;
        check1("req_before_edge", mem_req, 1'b0);
        tick();
        check1("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, RESET_PC);
        tick();
        check1("first_valid", inst_valid, 1'b1);
        check("first_inst_pc", inst_pc, RESET_PC);
        p0 = pop_cnt;
        repeat (10) tick();
        check("stream_rate", 32'(pop_cnt - p0), 32'd10);

        // Back-pressure fills the buffer, then drains in order.
        inst_ready = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        load_seq(RESET_PC);
        ack_cnt = 0;
        reset = 1'b0;
        repeat (20) tick();
        check1("bp_req_low", mem_req, 1'b0);
        check("bp_ack_count", 32'(ack_cnt), 32'd4);
        check1("bp_valid", inst_valid, 1'b1);
        check("bp_head_pc", inst_pc, RESET_PC);
        inst_ready = 1'b1;
        wait_pops(8, 80, "bp_drain_timeout");

        // Redirect table: delay 0 redirects with ack, others while waiting.
        for (int v = 0; v < 5; v++) begin
            mem_delay  = vecs[v].delay;
            inst_ready = 1'b1;
            k = 0;
            while (!(mem_req && ((vecs[v].delay == 0) ? mem_ack : !mem_ack)) && k < 50) begin
                tick();
                k++;
            end
            check1("vec_req_found", mem_req && ((vecs[v].delay == 0) ? mem_ack : !mem_ack), 1'b1);
            old = mem_addr;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].rd_pc;
            load_seq(vecs[v].exp_addr);
            tick();
            redirect_valid = 1'b0;
            check1("vec_flush_valid", inst_valid, 1'b0);
            if (vecs[v].delay != 0) begin
                check1("vec_drop_req", mem_req, 1'b1);
                check("vec_drop_addr", mem_addr, old);
            end else begin
                check1("vec_idle_req", mem_req, 1'b0);
            end
            wait_req_rise(40, rose);
            check1("vec_req_rise", rose, 1'b1);
            check("vec_new_addr", mem_addr, vecs[v].exp_addr);
            wait_pops(3, 80, "vec_pop_timeout");
        end

        // Second redirect while in DROP: the newest target wins.
        mem_delay = 4;
        k = 0;
        while (!(mem_req && !mem_ack) && k < 50) begin
            tick();
            k++;
        end
        check1("drop2_found", mem_req && !mem_ack, 1'b1);
        old = mem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        load_seq(32'h0000_0400);
        tick();
        redirect_pc = 32'h0000_0400;
        check1("drop2_req", mem_req, 1'b1);
        check("drop2_addr", mem_addr, old);
        tick();
        redirect_valid = 1'b0;
        wait_req_rise(40, rose);
        check1("drop2_rise", rose, 1'b1);
        check("drop2_new_addr", mem_addr, 32'h0000_0400);
        wait_pops(2, 80, "drop2_pop_timeout");

        // Reset mid-WAIT with a buffered instruction: outputs drop without a clock edge.
        inst_ready = 1'b0;
        mem_delay  = 3;
        k = 0;
        while (!(inst_valid && mem_req && !mem_ack) && k < 60) begin
            tick();
            k++;
        end
        check1("mid_reset_found", inst_valid && mem_req && !mem_ack, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check1("async_rst_req", mem_req, 1'b0);
        check1("async_rst_valid", inst_valid, 1'b0);
        repeat (2) tick();
        mem_delay  = 0;
        inst_ready = 1'b1;
        load_seq(RESET_PC);
        reset = 1'b0;
        tick();
        check1("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, RESET_PC);
        wait_pops(4, 40, "restart_pop_timeout");

        inst_ready = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
